// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the system-ID slave.
interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;

    modport master (output avm_address, avm_read, input avm_readdata);
    modport slave  (input avm_address, avm_read, output avm_readdata);
endinterface

// File: rtl/sysid_checker.sv
// Reads the system-ID and build-timestamp words after reset (and optionally on a
// timer), compares them with the build-time constants and holds a registered verdict.
module sysid_checker #(
    parameter logic [31:0] EXPECT_ID        = 32'd538186003,
    parameter logic [31:0] EXPECT_TIMESTAMP = 32'd1416068547,
    parameter int unsigned READ_LATENCY     = 0,
    parameter int unsigned RECHECK_CYCLES   = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    sysid_checker_if.master avm,
    output logic [31:0]     id_value,
    output logic [31:0]     timestamp_value,
    output logic            id_ok,
    output logic            ts_ok,
    output logic            match,
    output logic            done,
    output logic            mismatch_sticky
);
    typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CMP, DONE} state_t;

    localparam bit          NO_WAIT  = (READ_LATENCY == 0);
    localparam bit          RECHECK  = (RECHECK_CYCLES != 0);
    localparam logic [1:0]  LAT_LAST = NO_WAIT ? 2'd0 : 2'(READ_LATENCY - 1);
    localparam logic [23:0] RC_LAST  = RECHECK ? 24'(RECHECK_CYCLES - 1) : 24'd0;

    state_t      state, state_nx;
    logic [1:0]  lat_cnt, lat_nx;
    logic [23:0] rc_cnt, rc_nx;
    logic        cap_id, cap_ts, do_cmp, restart;
    logic        rd, addr;

    assign avm.avm_read    = rd;
    assign avm.avm_address = addr;

    // Address is a pure decode of state: it only moves when RD_ID / RD_TS is entered.
    always_comb begin
        state_nx = state;
        lat_nx   = lat_cnt;
        rc_nx    = rc_cnt;
        cap_id   = 1'b0;
        cap_ts   = 1'b0;
        do_cmp   = 1'b0;
        restart  = 1'b0;
        rd       = 1'b0;
        addr     = 1'b0;
        case (state)
            IDLE: state_nx = RD_ID;
            RD_ID: begin
                rd     = 1'b1;
                lat_nx = 2'd0;
                if (NO_WAIT) begin
                    cap_id   = 1'b1;
                    state_nx = RD_TS;
                end else begin
                    state_nx = WAIT_ID;
                end
            end
            WAIT_ID: begin
                if (lat_cnt == LAT_LAST) begin
                    cap_id   = 1'b1;
                    state_nx = RD_TS;
                end else begin
                    lat_nx = lat_cnt + 2'd1;
                end
            end
            RD_TS: begin
                rd     = 1'b1;
                addr   = 1'b1;
                lat_nx = 2'd0;
                if (NO_WAIT) begin
                    cap_ts   = 1'b1;
                    state_nx = CMP;
                end else begin
                    state_nx = WAIT_TS;
                end
            end
            WAIT_TS: begin
                addr = 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    cap_ts   = 1'b1;
                    state_nx = CMP;
                end else begin
                    lat_nx = lat_cnt + 2'd1;
                end
            end
            CMP: begin
                addr     = 1'b1;
                do_cmp   = 1'b1;
                rc_nx    = 24'd0;
                state_nx = DONE;
            end
            DONE: begin
                addr = 1'b1;
                // A start pulse coinciding with timer expiry still yields one restart.
                if (start || (RECHECK && rc_cnt == RC_LAST)) begin
                    restart  = 1'b1;
                    rc_nx    = 24'd0;
                    state_nx = RD_ID;
                end else if (RECHECK) begin
                    rc_nx = rc_cnt + 24'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            lat_cnt         <= 2'd0;
            rc_cnt          <= 24'd0;
            id_value        <= 32'd0;
            timestamp_value <= 32'd0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            match           <= 1'b0;
            done            <= 1'b0;
            mismatch_sticky <= 1'b0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_nx;
            rc_cnt  <= rc_nx;
            if (cap_id) id_value <= avm.avm_readdata;
            if (cap_ts) timestamp_value <= avm.avm_readdata;
            if (do_cmp) begin
                id_ok <= (id_value == EXPECT_ID);
                ts_ok <= (timestamp_value == EXPECT_TIMESTAMP);
                match <= (id_value == EXPECT_ID) && (timestamp_value == EXPECT_TIMESTAMP);
                done  <= 1'b1;
                if (!((id_value == EXPECT_ID) && (timestamp_value == EXPECT_TIMESTAMP)))
                    mismatch_sticky <= 1'b1;
            end
            if (restart) begin
                id_ok <= 1'b0;
                ts_ok <= 1'b0;
                match <= 1'b0;
                done  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a zero-latency/re-checking instance and a two-cycle-latency
// instance, each checked every cycle against a timeline model plus directed literals.
module tb_sysid_checker;
    localparam logic [31:0] EID = 32'd538186003;
    localparam logic [31:0] ETS = 32'd1416068547;
    localparam int L0 = 0, R0 = 16, L1 = 2, R1 = 0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  start_v;
    logic [31:0] id_v [2];
    logic [31:0] ts_v [2];
    logic [1:0]  idok_v, tsok_v, match_v, done_v, stk_v, rd_v, addr_v;
    logic [31:0] mem_id [2];
    logic [31:0] mem_ts [2];
    logic [1:0]  rd_d, a_d;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    sysid_checker_if bus0();
    sysid_checker_if bus1();

    sysid_checker #(.EXPECT_ID(EID), .EXPECT_TIMESTAMP(ETS), .READ_LATENCY(L0), .RECHECK_CYCLES(R0)) u0 (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .avm(bus0),
        .id_value(id_v[0]), .timestamp_value(ts_v[0]), .id_ok(idok_v[0]), .ts_ok(tsok_v[0]),
        .match(match_v[0]), .done(done_v[0]), .mismatch_sticky(stk_v[0]));

    sysid_checker #(.EXPECT_ID(EID), .EXPECT_TIMESTAMP(ETS), .READ_LATENCY(L1), .RECHECK_CYCLES(R1)) u1 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .avm(bus1),
        .id_value(id_v[1]), .timestamp_value(ts_v[1]), .id_ok(idok_v[1]), .ts_ok(tsok_v[1]),
        .match(match_v[1]), .done(done_v[1]), .mismatch_sticky(stk_v[1]));

    assign rd_v   = {bus1.avm_read, bus0.avm_read};
    assign addr_v = {bus1.avm_address, bus0.avm_address};

    // Slave 0 answers combinationally; slave 1 drives valid data only two cycles after the read.
    assign bus0.avm_readdata = addr_v[0] ? mem_ts[0] : mem_id[0];
    assign bus1.avm_readdata = rd_d[1] ? (a_d[1] ? mem_ts[1] : mem_id[1]) : 32'hBAD0_BAD0;

    always @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            rd_d <= 2'b00;
            a_d  <= 2'b00;
        end else begin
            rd_d <= {rd_d[0], rd_v[1]};
            a_d  <= {a_d[0], addr_v[1]};
        end

    // Edge numbering from reset release, read-strobe cycle counts and address history.
    int         edge_n;
    int         rd_cnt [2];
    logic [7:0] addr_seq [2];
    always @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            edge_n <= 0;
            for (int i = 0; i < 2; i++) begin
                rd_cnt[i]   <= 0;
                addr_seq[i] <= 8'd0;
            end
        end else begin
            edge_n <= edge_n + 1;
            for (int i = 0; i < 2; i++)
                if (rd_v[i]) begin
                    rd_cnt[i]   <= rd_cnt[i] + 1;
                    addr_seq[i] <= {addr_seq[i][6:0], addr_v[i]};
                end
        end

    function automatic int lat(input int i);
        return (i == 0) ? L0 : L1;
    endfunction
    function automatic int rck(input int i);
        return (i == 0) ? R0 : R1;
    endfunction

    // Timeline model: t counts edges since a check began (start edge = 0). ID is read at
    // t=0 and lands at t=L+1, TS is read at t=L+1 and lands at t=2L+2, verdict at t=2L+3.
    logic [1:0]  m_idle, m_act, m_idok, m_tsok, m_match, m_done, m_stk, m_addr;
    int          m_t [2];
    int          m_dcnt [2];
    logic [31:0] m_id [2];
    logic [31:0] m_ts [2];
    always @(posedge clock or negedge reset_n)
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_idle[i] <= 1'b1; m_act[i] <= 1'b0; m_t[i] <= 0; m_dcnt[i] <= 0;
                m_id[i] <= 32'd0; m_ts[i] <= 32'd0; m_idok[i] <= 1'b0; m_tsok[i] <= 1'b0;
                m_match[i] <= 1'b0; m_done[i] <= 1'b0; m_stk[i] <= 1'b0; m_addr[i] <= 1'b0;
            end else if (m_idle[i]) begin
                m_idle[i] <= 1'b0; m_act[i] <= 1'b1; m_t[i] <= 0; m_addr[i] <= 1'b0;
            end else if (m_act[i]) begin
                m_t[i] <= m_t[i] + 1;
                if (m_t[i] + 1 == lat(i) + 1) begin
                    m_id[i]   <= mem_id[i];
                    m_addr[i] <= 1'b1;
                end
                if (m_t[i] + 1 == 2 * lat(i) + 2) m_ts[i] <= mem_ts[i];
                if (m_t[i] + 1 == 2 * lat(i) + 3) begin
                    m_idok[i]  <= (m_id[i] == EID);
                    m_tsok[i]  <= (m_ts[i] == ETS);
                    m_match[i] <= (m_id[i] == EID) && (m_ts[i] == ETS);
                    m_done[i]  <= 1'b1;
                    if (!((m_id[i] == EID) && (m_ts[i] == ETS))) m_stk[i] <= 1'b1;
                    m_act[i]  <= 1'b0;
                    m_dcnt[i] <= 0;
                end
            end else if (start_v[i] || (rck(i) > 0 && m_dcnt[i] == rck(i) - 1)) begin
                m_done[i] <= 1'b0; m_idok[i] <= 1'b0; m_tsok[i] <= 1'b0; m_match[i] <= 1'b0;
                m_act[i] <= 1'b1; m_t[i] <= 0; m_addr[i] <= 1'b0;
            end else begin
                m_dcnt[i] <= m_dcnt[i] + 1;
            end
        end

    task automatic chk1(input string nm, input int i, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] @%0t: got %b, want %b", nm, i, $time, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] @%0t: got %0h, want %0h", nm, i, $time, act, exp);
        end
    endtask

    // Advance one cycle and compare both instances against the model.
    task automatic step();
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk1("avm_read", i, rd_v[i], m_act[i] && (m_t[i] == 0 || m_t[i] == lat(i) + 1));
            chk1("avm_address", i, addr_v[i], m_addr[i]);
            chk32("id_value", i, id_v[i], m_id[i]);
            chk32("timestamp_value", i, ts_v[i], m_ts[i]);
            chk1("id_ok", i, idok_v[i], m_idok[i]);
            chk1("ts_ok", i, tsok_v[i], m_tsok[i]);
            chk1("match", i, match_v[i], m_match[i]);
            chk1("done", i, done_v[i], m_done[i]);
            chk1("mismatch_sticky", i, stk_v[i], m_stk[i]);
        end
    endtask

    task automatic wait_lvl(input int i, input logic lvl, input int budget, output int e);
        e = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (done_v[i] == lvl) begin
                e = edge_n;
                break;
            end
        end
        if (e < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_done[u%0d]: level %0b not seen within %0d cycles", i, lvl, budget);
        end
    endtask

    int e;

    initial begin
        reset_n = 1'b0;
        start_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            mem_id[i] = EID;
            mem_ts[i] = ETS;
        end
        repeat (3) step();
        chk1("rst_done", 0, done_v[0], 1'b0);
        chk32("rst_id_value", 1, id_v[1], 32'd0);
        reset_n = 1'b1;

        // start while u1 sits in WAIT_ID must be dropped
        step();
        step();
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;

        wait_lvl(0, 1'b1, 20, e);
        chk32("done_edge", 0, e, 32'd4);
        chk1("first_match", 0, match_v[0], 1'b1);
        chk1("first_sticky", 0, stk_v[0], 1'b0);
        chk32("first_id", 0, id_v[0], 32'd538186003);
        chk32("read_cycles", 0, rd_cnt[0], 32'd2);
        chk32("addr_order", 0, {24'd0, addr_seq[0]}, 32'h1);
        mem_id[0] = 32'h1234_5678;

        wait_lvl(1, 1'b1, 20, e);
        chk32("done_edge", 1, e, 32'd8);
        chk32("read_cycles", 1, rd_cnt[1], 32'd2);
        chk32("addr_order", 1, {24'd0, addr_seq[1]}, 32'h1);
        chk32("first_ts", 1, ts_v[1], 32'd1416068547);
        chk1("first_match", 1, match_v[1], 1'b1);

        // periodic re-check sees the altered ID
        wait_lvl(0, 1'b0, 30, e);
        chk32("recheck_edge", 0, e, 32'd20);
        wait_lvl(0, 1'b1, 20, e);
        chk32("recheck_done_edge", 0, e, 32'd23);
        chk1("recheck_match", 0, match_v[0], 1'b0);
        chk1("recheck_id_ok", 0, idok_v[0], 1'b0);
        chk1("recheck_ts_ok", 0, tsok_v[0], 1'b1);
        chk1("recheck_sticky", 0, stk_v[0], 1'b1);
        chk32("recheck_id", 0, id_v[0], 32'h1234_5678);
        chk32("no_extra_reads", 1, rd_cnt[1], 32'd2);
        mem_id[0] = EID;

        // start in DONE restarts u1
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        chk1("start_clears_done", 1, done_v[1], 1'b0);
        wait_lvl(1, 1'b1, 20, e);
        chk32("restart_done_edge", 1, e, 32'd31);
        chk32("restart_reads", 1, rd_cnt[1], 32'd4);

        wait_lvl(0, 1'b0, 30, e);
        wait_lvl(0, 1'b1, 20, e);
        chk32("third_done_edge", 0, e, 32'd42);
        chk1("third_match", 0, match_v[0], 1'b1);
        chk1("sticky_holds", 0, stk_v[0], 1'b1);

        // reset while u0 is in RD_TS of its next re-check
        wait_lvl(0, 1'b0, 30, e);
        step();
        chk1("in_rd_ts_read", 0, rd_v[0], 1'b1);
        chk1("in_rd_ts_addr", 0, addr_v[0], 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk32("async_id_value", 0, id_v[0], 32'd0);
        chk32("async_ts_value", 0, ts_v[0], 32'd0);
        chk1("async_sticky", 0, stk_v[0], 1'b0);
        chk1("async_addr", 0, addr_v[0], 1'b0);
        chk1("async_done", 1, done_v[1], 1'b0);
        chk1("async_match", 1, match_v[1], 1'b0);
        mem_ts[0] = 32'h0000_0000;
        step();
        reset_n = 1'b1;

        wait_lvl(0, 1'b1, 20, e);
        chk32("post_reset_done_edge", 0, e, 32'd4);
        chk32("post_reset_addr_order", 0, {24'd0, addr_seq[0]}, 32'h1);
        chk1("ts_zero_id_ok", 0, idok_v[0], 1'b1);
        chk1("ts_zero_ts_ok", 0, tsok_v[0], 1'b0);
        chk1("ts_zero_match", 0, match_v[0], 1'b0);
        chk1("ts_zero_sticky", 0, stk_v[0], 1'b1);
        wait_lvl(1, 1'b1, 20, e);
        chk32("post_reset_done_edge", 1, e, 32'd8);
        chk1("post_reset_match", 1, match_v[1], 1'b1);
        chk1("post_reset_sticky", 1, stk_v[1], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
